// File: rtl/svga_timing_rx.sv
// svga_timing_rx: samples hsync/vsync on the pixel clock, measures line and frame
// timing, recovers col/line position, declares lock and regenerates display enable.
module svga_timing_rx #(
  parameter int CW          = 12,
  parameter int LW          = 11,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1,
  parameter int LOCK_FRAMES = 2,
  parameter int H_ACT_START = 216,
  parameter int H_ACT       = 800,
  parameter int V_ACT_START = 27,
  parameter int V_ACT       = 600
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [CW-1:0] col,
  output logic [LW-1:0] line,
  output logic          de,
  output logic          locked,
  output logic          frame_start,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_sync_len,
  output logic [LW-1:0] v_total,
  output logic [LW-1:0] v_sync_len
);

  localparam int SW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] C_MAX  = {CW{1'b1}};
  localparam logic [LW-1:0] L_MAX  = {LW{1'b1}};
  localparam logic [CW-1:0] H_BEG  = CW'(H_ACT_START);
  localparam logic [CW-1:0] H_END  = CW'(H_ACT_START + H_ACT);
  localparam logic [LW-1:0] V_BEG  = LW'(V_ACT_START);
  localparam logic [LW-1:0] V_END  = LW'(V_ACT_START + V_ACT);
  localparam logic [SW-1:0] ST_MAX = SW'(LOCK_FRAMES);

  logic          hs_meta_q, hs_meta_d, hs_sync_q, hs_sync_d, hs_prev_q, hs_prev_d;
  logic          vs_meta_q, vs_meta_d, vs_sync_q, vs_sync_d, vs_prev_q, vs_prev_d;
  logic [CW-1:0] col_q, col_d, hw_q, hw_d, h_total_q, h_total_d, h_sync_len_q, h_sync_len_d;
  logic [LW-1:0] line_q, line_d, vw_q, vw_d, v_total_q, v_total_d, v_sync_len_q, v_sync_len_d;
  logic          pend_q, pend_d, locked_q, locked_d, de_q, de_d, fs_q, fs_d;
  logic [SW-1:0] stable_q, stable_d;
  logic          hs_rise, hs_fall, vs_rise, vs_fall, frame_evt, h_mismatch;

  always_comb begin
    // Polarity is folded in ahead of the flops so the reset state reads as inactive.
    hs_meta_d = hsync_in ^ ~HS_POL;
    vs_meta_d = vsync_in ^ ~VS_POL;
    hs_sync_d = hs_meta_q;
    vs_sync_d = vs_meta_q;
    hs_prev_d = hs_sync_q;
    vs_prev_d = vs_sync_q;
    hs_rise   = hs_sync_q & ~hs_prev_q;
    hs_fall   = ~hs_sync_q & hs_prev_q;
    vs_rise   = vs_sync_q & ~vs_prev_q;
    vs_fall   = ~vs_sync_q & vs_prev_q;

    col_d      = (col_q == C_MAX) ? col_q : col_q + CW'(1);
    h_total_d  = h_total_q;
    h_mismatch = 1'b0;
    if (hs_rise) begin
      col_d      = '0;
      h_total_d  = col_q + CW'(1);
      h_mismatch = (h_total_d != h_total_q);
    end

    hw_d = '0;
    if (hs_sync_q) hw_d = (hw_q == C_MAX) ? hw_q : hw_q + CW'(1);
    h_sync_len_d = hs_fall ? hw_q : h_sync_len_q;

    frame_evt = hs_rise & (pend_q | vs_rise);
    fs_d      = frame_evt;
    pend_d    = pend_q | vs_rise;
    line_d    = line_q;
    v_total_d = v_total_q;
    if (frame_evt) begin
      pend_d    = 1'b0;
      line_d    = '0;
      v_total_d = line_q + LW'(1);
    end else if (hs_rise && line_q != L_MAX) begin
      line_d = line_q + LW'(1);
    end

    vw_d = '0;
    if (vs_sync_q) vw_d = (hs_rise && vw_q != L_MAX) ? vw_q + LW'(1) : vw_q;
    v_sync_len_d = vs_fall ? vw_q : v_sync_len_q;

    stable_d = stable_q;
    if (frame_evt) begin
      if (v_total_d == v_total_q) stable_d = (stable_q == ST_MAX) ? stable_q : stable_q + SW'(1);
      else                        stable_d = '0;
    end
    // A line-length change or a runaway column counter both invalidate the history.
    if (h_mismatch || col_d == C_MAX) stable_d = '0;
    locked_d = (stable_d == ST_MAX);

    de_d = locked_d && (col_d >= H_BEG) && (col_d < H_END) &&
           (line_d >= V_BEG) && (line_d < V_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_meta_q    <= 1'b0;
      hs_sync_q    <= 1'b0;
      hs_prev_q    <= 1'b0;
      vs_meta_q    <= 1'b0;
      vs_sync_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      col_q        <= '0;
      line_q       <= '0;
      hw_q         <= '0;
      vw_q         <= '0;
      h_total_q    <= '0;
      h_sync_len_q <= '0;
      v_total_q    <= '0;
      v_sync_len_q <= '0;
      pend_q       <= 1'b0;
      stable_q     <= '0;
      locked_q     <= 1'b0;
      de_q         <= 1'b0;
      fs_q         <= 1'b0;
    end else begin
      hs_meta_q    <= hs_meta_d;
      hs_sync_q    <= hs_sync_d;
      hs_prev_q    <= hs_prev_d;
      vs_meta_q    <= vs_meta_d;
      vs_sync_q    <= vs_sync_d;
      vs_prev_q    <= vs_prev_d;
      col_q        <= col_d;
      line_q       <= line_d;
      hw_q         <= hw_d;
      vw_q         <= vw_d;
      h_total_q    <= h_total_d;
      h_sync_len_q <= h_sync_len_d;
      v_total_q    <= v_total_d;
      v_sync_len_q <= v_sync_len_d;
      pend_q       <= pend_d;
      stable_q     <= stable_d;
      locked_q     <= locked_d;
      de_q         <= de_d;
      fs_q         <= fs_d;
    end
  end

  assign col         = col_q;
  assign line        = line_q;
  assign de          = de_q;
  assign locked      = locked_q;
  assign frame_start = fs_q;
  assign h_total     = h_total_q;
  assign h_sync_len  = h_sync_len_q;
  assign v_total     = v_total_q;
  assign v_sync_len  = v_sync_len_q;

endmodule

// File: tb/tb_svga_timing_rx.sv
// tb_svga_timing_rx: drives a scaled-down SVGA-style sync stream into a positive- and a
// negative-polarity receiver and checks measurements, lock, de, saturation and reset.
module tb_svga_timing_rx;

  // Scaled timing keeps whole-frame runs short; structure mirrors 800x600 SVGA.
  localparam int HT = 64, HSW = 8, VT = 20, VSW = 2;
  localparam int HAS = 16, HA = 40, VAS = 5, VA = 12;
  localparam int FRAME = HT * VT;

  logic clk, rst_n, hs_p, vs_p, hs_n, vs_n;

  logic [11:0] p_col, p_ht, p_hsl, n_col, n_ht, n_hsl;
  logic [10:0] p_line, p_vt, p_vsl, n_line, n_vt, n_vsl;
  logic        p_de, p_locked, p_fs, n_de, n_locked, n_fs;
  logic [71:0] p_all, n_all;

  assign p_all = {p_col, p_line, p_de, p_locked, p_fs, p_ht, p_hsl, p_vt, p_vsl};
  assign n_all = {n_col, n_line, n_de, n_locked, n_fs, n_ht, n_hsl, n_vt, n_vsl};

  int tests_run, tests_failed, cyc;
  int gen_col, gen_line, perturb_line;
  bit gen_on;
  int lock_fs_p, lock_fs_n;

  svga_timing_rx #(.H_ACT_START(HAS), .H_ACT(HA), .V_ACT_START(VAS), .V_ACT(VA)) dut_p (
    .clk(clk), .rst_n(rst_n), .hsync_in(hs_p), .vsync_in(vs_p),
    .col(p_col), .line(p_line), .de(p_de), .locked(p_locked), .frame_start(p_fs),
    .h_total(p_ht), .h_sync_len(p_hsl), .v_total(p_vt), .v_sync_len(p_vsl)
  );

  svga_timing_rx #(.HS_POL(1'b0), .VS_POL(1'b0),
                   .H_ACT_START(HAS), .H_ACT(HA), .V_ACT_START(VAS), .V_ACT(VA)) dut_n (
    .clk(clk), .rst_n(rst_n), .hsync_in(hs_n), .vsync_in(vs_n),
    .col(n_col), .line(n_line), .de(n_de), .locked(n_locked), .frame_start(n_fs),
    .h_total(n_ht), .h_sync_len(n_hsl), .v_total(n_vt), .v_sync_len(n_vsl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // One clock: sample point is the falling edge, then drive the next pixel's syncs.
  task automatic step();
    int len;
    @(negedge clk);
    cyc++;
    hs_p = gen_on && (gen_col < HSW);
    vs_p = gen_on && (gen_line < VSW);
    hs_n = ~hs_p;
    vs_n = ~vs_p;
    if (gen_on) begin
      len = (gen_line == perturb_line) ? HT + 1 : HT;
      gen_col++;
      if (gen_col >= len) begin
        gen_col = 0;
        if (gen_line == perturb_line) perturb_line = -1;
        gen_line = (gen_line + 1) % VT;
      end
    end
  endtask

  task automatic restart();
    rst_n = 1'b0;
    gen_on = 1'b0;
    gen_col = 0;
    gen_line = 0;
    perturb_line = -1;
    repeat (3) step();
    rst_n = 1'b1;
    gen_on = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    gen_on = 1'b0;
    repeat (3) step();
    tests_run++;
    if (p_all !== '0 || n_all !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: p=%h n=%h required all zero", p_all, n_all);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      tests_run++;
      if (p_col !== 12'(k) || p_line !== 11'd0) begin
        tests_failed++;
        $display("FAIL free_count: col=%0d line=%0d required col=%0d line=0", p_col, p_line, k);
      end
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_clean_lock();
    int fs_n, last_fs, k;
    restart();
    fs_n = 0; last_fs = 0; lock_fs_p = 0; lock_fs_n = 0; k = 0;
    while (fs_n < 6 && k < 8 * FRAME) begin
      step();
      k++;
      if (p_fs) begin
        fs_n++;
        if (fs_n >= 2) begin
          tests_run++;
          if (cyc - last_fs != FRAME) begin
            tests_failed++;
            $display("FAIL fs_period: got %0d clocks required %0d", cyc - last_fs, FRAME);
          end
        end
        last_fs = cyc;
        tests_run++;
        if (p_locked !== (fs_n >= 4)) begin
          tests_failed++;
          $display("FAIL lock_at_fs%0d: locked=%0b required %0b", fs_n, p_locked, fs_n >= 4);
        end
      end
      if (p_locked && lock_fs_p == 0) lock_fs_p = fs_n;
      if (n_locked && lock_fs_n == 0) lock_fs_n = fs_n;
    end
    tests_run++;
    if (fs_n != 6) begin
      tests_failed++;
      $display("FAIL fs_count: saw %0d frame starts required 6", fs_n);
    end
    tests_run++;
    if (lock_fs_p != 4) begin
      tests_failed++;
      $display("FAIL lock_rise_p: rose at frame_start %0d required 4", lock_fs_p);
    end
    tests_run++;
    if (p_ht !== 12'd64 || p_hsl !== 12'd8 || p_vt !== 11'd20 || p_vsl !== 11'd2) begin
      tests_failed++;
      $display("FAIL measure_p: ht=%0d hsl=%0d vt=%0d vsl=%0d required 64 8 20 2",
               p_ht, p_hsl, p_vt, p_vsl);
    end
    $display("[TB] test_clean_lock done");
  endtask

  task automatic test_neg_polarity();
    tests_run++;
    if (lock_fs_n != 4) begin
      tests_failed++;
      $display("FAIL lock_rise_n: rose at frame_start %0d required 4", lock_fs_n);
    end
    tests_run++;
    if (n_ht !== 12'd64 || n_hsl !== 12'd8 || n_vt !== 11'd20 || n_vsl !== 11'd2) begin
      tests_failed++;
      $display("FAIL measure_n: ht=%0d hsl=%0d vt=%0d vsl=%0d required 64 8 20 2",
               n_ht, n_hsl, n_vt, n_vsl);
    end
    $display("[TB] test_neg_polarity done");
  endtask

  task automatic test_de();
    int k, de_total, line_de, bad_end, bad_line, first_col, first_line, exp_line;
    bit seen;
    k = 0;
    do begin step(); k++; end while (!p_fs && k < 2 * FRAME);
    tests_run++;
    if (!p_fs) begin
      tests_failed++;
      $display("FAIL de_sync: frame_start=%0b required 1 within budget", p_fs);
    end
    de_total = 0; line_de = 0; bad_end = 0; bad_line = 0; seen = 0;
    first_col = -1; first_line = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (p_de) begin
        de_total++;
        line_de++;
        if (!seen) begin first_col = p_col; first_line = p_line; seen = 1; end
        if (p_col == HAS + HA || p_line == VAS + VA) bad_end++;
      end
      if (p_col == HT - 1) begin
        exp_line = (p_line >= VAS && p_line < VAS + VA) ? HA : 0;
        if (line_de != exp_line) bad_line++;
        line_de = 0;
      end
      step();
    end
    tests_run++;
    if (first_col != HAS || first_line != VAS) begin
      tests_failed++;
      $display("FAIL de_first: col=%0d line=%0d required %0d %0d", first_col, first_line, HAS, VAS);
    end
    tests_run++;
    if (de_total != HA * VA) begin
      tests_failed++;
      $display("FAIL de_total: got %0d required %0d", de_total, HA * VA);
    end
    tests_run++;
    if (bad_line != 0) begin
      tests_failed++;
      $display("FAIL de_per_line: %0d lines with wrong de count required 0", bad_line);
    end
    tests_run++;
    if (bad_end != 0) begin
      tests_failed++;
      $display("FAIL de_bounds: %0d de cycles at end col/line required 0", bad_end);
    end
    $display("[TB] test_de done");
  endtask

  task automatic test_perturb();
    int k, fs;
    k = 0;
    while (gen_line != 2 && k < 2 * FRAME) begin step(); k++; end
    perturb_line = 8;
    k = 0;
    do begin step(); k++; end while (p_locked && k < 2 * FRAME);
    tests_run++;
    if (p_locked !== 1'b0 || p_ht !== 12'd65 || p_line !== 11'd9 || p_col !== 12'd0) begin
      tests_failed++;
      $display("FAIL perturb_drop: locked=%0b ht=%0d line=%0d col=%0d required 0 65 9 0",
               p_locked, p_ht, p_line, p_col);
    end
    k = 0;
    do begin step(); k++; end while (!(p_line == 11'd10 && p_col == 12'd0) && k < 2 * HT);
    tests_run++;
    if (p_locked !== 1'b0 || p_ht !== 12'd64 || p_line !== 11'd10) begin
      tests_failed++;
      $display("FAIL perturb_next: locked=%0b ht=%0d line=%0d required 0 64 10",
               p_locked, p_ht, p_line);
    end
    fs = 0; k = 0;
    while (fs < 2 && k < 3 * FRAME) begin
      step();
      k++;
      if (p_fs) begin
        fs++;
        tests_run++;
        if (p_locked !== (fs == 2)) begin
          tests_failed++;
          $display("FAIL relock_fs%0d: locked=%0b required %0b", fs, p_locked, fs == 2);
        end
      end
    end
    tests_run++;
    if (fs != 2) begin
      tests_failed++;
      $display("FAIL relock_timeout: saw %0d frame starts required 2", fs);
    end
    $display("[TB] test_perturb done");
  endtask

  task automatic test_saturate();
    int k;
    logic prev_lock;
    gen_on = 1'b0;
    prev_lock = p_locked;
    k = 0;
    while (p_col != 12'd4095 && k < 6000) begin
      prev_lock = p_locked;
      step();
      k++;
    end
    tests_run++;
    if (p_col !== 12'd4095 || prev_lock !== 1'b1 || p_locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_reach: col=%0d prev_locked=%0b locked=%0b required 4095 1 0",
               p_col, prev_lock, p_locked);
    end
    repeat (10) step();
    tests_run++;
    if (p_col !== 12'd4095 || p_locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_hold: col=%0d locked=%0b required 4095 0", p_col, p_locked);
    end
    gen_col = 0;
    gen_line = 0;
    gen_on = 1'b1;
    repeat (3) step();
    tests_run++;
    if (p_col !== 12'd4095) begin
      tests_failed++;
      $display("FAIL restart_latency: col=%0d required 4095 before reload", p_col);
    end
    step();
    tests_run++;
    if (p_col !== 12'd0 || p_ht !== 12'd0 || p_fs !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_reload: col=%0d ht=%0d fs=%0b required 0 0 1", p_col, p_ht, p_fs);
    end
    $display("[TB] test_saturate done");
  endtask

  task automatic test_reset_midstream();
    repeat (2 * HT) step();
    tests_run++;
    if (p_ht !== 12'd64) begin
      tests_failed++;
      $display("FAIL pre_reset_ht: ht=%0d required 64", p_ht);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (p_all !== '0 || n_all !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: p=%h n=%h required all zero", p_all, n_all);
    end
    repeat (5) step();
    tests_run++;
    if (p_all !== '0 || n_all !== '0) begin
      tests_failed++;
      $display("FAIL reset_hold: p=%h n=%h required all zero", p_all, n_all);
    end
    rst_n = 1'b1;
    step();
    tests_run++;
    if (p_col !== 12'd1 || p_line !== 11'd0 || n_col !== 12'd1) begin
      tests_failed++;
      $display("FAIL reset_release: col=%0d line=%0d ncol=%0d required 1 0 1", p_col, p_line, n_col);
    end
    $display("[TB] test_reset_midstream done");
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; cyc = 0;
    gen_on = 1'b0; gen_col = 0; gen_line = 0; perturb_line = -1;
    lock_fs_p = 0; lock_fs_n = 0;
    rst_n = 1'b0; hs_p = 1'b0; vs_p = 1'b0; hs_n = 1'b1; vs_n = 1'b1;
    test_reset();
    test_clean_lock();
    test_neg_polarity();
    test_de();
    test_perturb();
    test_saturate();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
